// File: rtl/mem_refill_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_refill_arbiter_if
// Block-wide memory port shared by the instruction and data caches.
//
// Signals:
//   mem_rd_req  block read request (arbiter -> memory)
//   mem_wr_req  block write request (arbiter -> memory)
//   mem_addr    request address (arbiter -> memory)
//   mem_wdata   write-back block (arbiter -> memory)
//   mem_ready   request accepted this cycle (memory -> arbiter)
//   mem_done    transaction complete, mem_rdata valid (memory -> arbiter)
//   mem_rdata   refill block (memory -> arbiter)
//
// Modports: master = arbiter side, slave = memory side.
// ---------------------------------------------------------------------------
interface mem_refill_arbiter_if #(
    parameter int ADDR_WIDTH  = 64,
    parameter int BLOCK_WIDTH = 512
);
    logic                   mem_rd_req;
    logic                   mem_wr_req;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic [BLOCK_WIDTH-1:0] mem_wdata;
    logic                   mem_ready;
    logic                   mem_done;
    logic [BLOCK_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_rd_req, mem_wr_req, mem_addr, mem_wdata,
        input  mem_ready, mem_done, mem_rdata
    );

    modport slave (
        input  mem_rd_req, mem_wr_req, mem_addr, mem_wdata,
        output mem_ready, mem_done, mem_rdata
    );
endinterface

// File: rtl/mem_refill_arbiter.sv
// ---------------------------------------------------------------------------
// mem_refill_arbiter
// Sequences block-level memory traffic for the cache hierarchy. One memory
// port is shared between icache and dcache misses; dirty dcache misses write
// the victim back before the refill read. The refill block is returned with a
// one-cycle block write enable, and the pipeline is stalled while any miss is
// outstanding.
//
// Configuration macro: MEM_ARB_ROUND_ROBIN_EN
//   defined   -> round-robin arbitration on simultaneous misses
//   undefined -> fixed priority, dcache over icache
//
// Ports:
//   i_clk, i_arst          clock, asynchronous active-low reset
//   i_icache_miss/addr     instruction-cache miss request
//   i_dcache_miss/dirty    data-cache miss and victim-dirty flag
//   i_dcache_addr          data miss address
//   i_dcache_addr_wb       victim write-back address
//   i_dcache_block         victim block data
//   io_mem                 memory port (master modport)
//   o_refill_block         block written into the granted cache
//   o_icache_block_we      icache block write pulse
//   o_dcache_block_we      dcache block write pulse
//   o_stall                pipeline stall
// ---------------------------------------------------------------------------
module mem_refill_arbiter #(
    parameter int ADDR_WIDTH  = 64,
    parameter int BLOCK_WIDTH = 512
) (
    input  logic                    i_clk,
    input  logic                    i_arst,
    input  logic                    i_icache_miss,
    input  logic [ADDR_WIDTH-1:0]   i_icache_addr,
    input  logic                    i_dcache_miss,
    input  logic                    i_dcache_dirty,
    input  logic [ADDR_WIDTH-1:0]   i_dcache_addr,
    input  logic [ADDR_WIDTH-1:0]   i_dcache_addr_wb,
    input  logic [BLOCK_WIDTH-1:0]  i_dcache_block,
    mem_refill_arbiter_if.master    io_mem,
    output logic [BLOCK_WIDTH-1:0]  o_refill_block,
    output logic                    o_icache_block_we,
    output logic                    o_dcache_block_we,
    output logic                    o_stall
);

    localparam int OFFSET_BITS = $clog2(BLOCK_WIDTH / 8);
    // Clears the byte-offset bits so reads are block aligned.
    localparam logic [ADDR_WIDTH-1:0] BLOCK_MASK =
        {{(ADDR_WIDTH - OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        WB_REQ,
        WB_WAIT,
        RD_REQ,
        RD_WAIT,
        FILL
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   r_grant_d;
    logic                   w_pick_d;
    logic                   w_any_miss;
    logic [ADDR_WIDTH-1:0]  r_miss_addr;
    logic [ADDR_WIDTH-1:0]  r_wb_addr;
    logic [BLOCK_WIDTH-1:0] r_wb_data;
    logic [BLOCK_WIDTH-1:0] r_refill;

    assign w_any_miss = i_icache_miss | i_dcache_miss;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Remembers whether the dcache won the last grant.
    logic r_last_d;

    // On a tie, the requester that was not granted last wins.
    always_comb begin
        w_pick_d = i_dcache_miss;
        if (i_dcache_miss && i_icache_miss) begin
            w_pick_d = ~r_last_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            r_last_d <= 1'b0;
        end else if (r_state == IDLE && w_any_miss) begin
            r_last_d <= w_pick_d;
        end
    end
`else
    // Fixed priority: any dcache miss beats the icache.
    always_comb begin
        w_pick_d = i_dcache_miss;
    end
`endif

    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Memory done is only looked at in the WAIT states, so a stray done
    // elsewhere cannot move the FSM.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_any_miss) begin
                    w_next_state = (w_pick_d && i_dcache_dirty) ? WB_REQ : RD_REQ;
                end
            end
            WB_REQ:  if (io_mem.mem_ready) w_next_state = WB_WAIT;
            WB_WAIT: if (io_mem.mem_done)  w_next_state = RD_REQ;
            RD_REQ:  if (io_mem.mem_ready) w_next_state = RD_WAIT;
            RD_WAIT: if (io_mem.mem_done)  w_next_state = FILL;
            FILL:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Grant, miss address and victim are captured once in IDLE and held for
    // the whole sequence, so a miss dropping mid-flight has no effect.
    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            r_grant_d   <= 1'b0;
            r_miss_addr <= '0;
            r_wb_addr   <= '0;
            r_wb_data   <= '0;
            r_refill    <= '0;
        end else begin
            if (r_state == IDLE && w_any_miss) begin
                r_grant_d   <= w_pick_d;
                r_miss_addr <= w_pick_d ? i_dcache_addr : i_icache_addr;
                if (w_pick_d && i_dcache_dirty) begin
                    r_wb_addr <= i_dcache_addr_wb;
                    r_wb_data <= i_dcache_block;
                end
            end
            if (r_state == RD_WAIT && io_mem.mem_done) begin
                r_refill <= io_mem.mem_rdata;
            end
        end
    end

    // Bus outputs come only from state and latched registers.
    always_comb begin
        io_mem.mem_rd_req  = 1'b0;
        io_mem.mem_wr_req  = 1'b0;
        io_mem.mem_addr    = '0;
        io_mem.mem_wdata   = '0;
        o_refill_block     = '0;
        o_icache_block_we  = 1'b0;
        o_dcache_block_we  = 1'b0;
        case (r_state)
            WB_REQ: begin
                io_mem.mem_wr_req = 1'b1;
                io_mem.mem_addr   = r_wb_addr;
                io_mem.mem_wdata  = r_wb_data;
            end
            RD_REQ: begin
                io_mem.mem_rd_req = 1'b1;
                io_mem.mem_addr   = r_miss_addr & BLOCK_MASK;
            end
            FILL: begin
                o_refill_block    = r_refill;
                o_icache_block_we = ~r_grant_d;
                o_dcache_block_we = r_grant_d;
            end
            default: begin
            end
        endcase
    end

    assign o_stall = w_any_miss | (r_state != IDLE);

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_refill_arbiter
// Directed self-checking bench for mem_refill_arbiter. Inputs change 2 ns
// after each rising edge and outputs are observed at that same point.
// Honours MEM_ARB_ROUND_ROBIN_EN for the simultaneous-miss ordering.
// ---------------------------------------------------------------------------
module tb_mem_refill_arbiter;

    localparam int AW = 64;
    localparam int BW = 512;

    logic          i_clk = 1'b0;
    logic          i_arst;
    logic          i_icache_miss;
    logic [AW-1:0] i_icache_addr;
    logic          i_dcache_miss;
    logic          i_dcache_dirty;
    logic [AW-1:0] i_dcache_addr;
    logic [AW-1:0] i_dcache_addr_wb;
    logic [BW-1:0] i_dcache_block;
    logic [BW-1:0] o_refill_block;
    logic          o_icache_block_we;
    logic          o_dcache_block_we;
    logic          o_stall;

    int errorCount = 0;
    int checkCount = 0;

    mem_refill_arbiter_if #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW)) memIf ();

    mem_refill_arbiter #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW)) dut (
        .i_clk             (i_clk),
        .i_arst            (i_arst),
        .i_icache_miss     (i_icache_miss),
        .i_icache_addr     (i_icache_addr),
        .i_dcache_miss     (i_dcache_miss),
        .i_dcache_dirty    (i_dcache_dirty),
        .i_dcache_addr     (i_dcache_addr),
        .i_dcache_addr_wb  (i_dcache_addr_wb),
        .i_dcache_block    (i_dcache_block),
        .io_mem            (memIf),
        .o_refill_block    (o_refill_block),
        .o_icache_block_we (o_icache_block_we),
        .o_dcache_block_we (o_dcache_block_we),
        .o_stall           (o_stall)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [BW-1:0] observed,
                               input logic [BW-1:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic applyStimulus(input logic icMiss, input logic [AW-1:0] icAddr,
                                 input logic dcMiss, input logic dcDirty,
                                 input logic [AW-1:0] dcAddr, input logic [AW-1:0] dcWbAddr,
                                 input logic [BW-1:0] dcBlock);
        i_icache_miss    = icMiss;
        i_icache_addr    = icAddr;
        i_dcache_miss    = dcMiss;
        i_dcache_dirty   = dcDirty;
        i_dcache_addr    = dcAddr;
        i_dcache_addr_wb = dcWbAddr;
        i_dcache_block   = dcBlock;
    endtask

    // Called in the WB_REQ cycle; ready is withheld for holdCycles first.
    task automatic runWriteBack(input logic [AW-1:0] expAddr, input logic [BW-1:0] expData,
                                input int holdCycles);
        for (int i = 0; i <= holdCycles; i++) begin
            checkOutput("wb_req", memIf.mem_wr_req, 1'b1);
            checkOutput("wb_addr", memIf.mem_addr, expAddr);
            checkOutput("wb_data", memIf.mem_wdata, expData);
            checkOutput("wb_no_rd", memIf.mem_rd_req, 1'b0);
            if (i < holdCycles) tick();
        end
        memIf.mem_ready = 1'b1;
        tick();
        memIf.mem_ready = 1'b0;
        checkOutput("wb_wait_req", memIf.mem_wr_req, 1'b0);
        checkOutput("wb_wait_data", memIf.mem_wdata, '0);
        tick();
        memIf.mem_done = 1'b1;
        tick();
        memIf.mem_done = 1'b0;
    endtask

    // Called in the RD_REQ cycle; finishes in the IDLE cycle after FILL.
    task automatic runRead(input logic isD, input logic [AW-1:0] expAddr,
                           input logic [BW-1:0] pattern);
        checkOutput("rd_req", memIf.mem_rd_req, 1'b1);
        checkOutput("rd_addr", memIf.mem_addr, expAddr);
        checkOutput("rd_no_wr", memIf.mem_wr_req, 1'b0);
        memIf.mem_ready = 1'b1;
        tick();
        memIf.mem_ready = 1'b0;
        checkOutput("rd_wait_req", memIf.mem_rd_req, 1'b0);
        tick();
        tick();
        checkOutput("no_early_we", o_icache_block_we | o_dcache_block_we, 1'b0);
        memIf.mem_done  = 1'b1;
        memIf.mem_rdata = pattern;
        tick();
        memIf.mem_done  = 1'b0;
        memIf.mem_rdata = '0;
        checkOutput("fill_ic_we", o_icache_block_we, !isD);
        checkOutput("fill_dc_we", o_dcache_block_we, isD);
        checkOutput("fill_block", o_refill_block, pattern);
        checkOutput("fill_stall", o_stall, 1'b1);
        if (isD) i_dcache_miss = 1'b0;
        else     i_icache_miss = 1'b0;
        tick();
        checkOutput("post_ic_we", o_icache_block_we, 1'b0);
        checkOutput("post_dc_we", o_dcache_block_we, 1'b0);
    endtask

    initial begin
        i_arst          = 1'b0;
        memIf.mem_ready = 1'b0;
        memIf.mem_done  = 1'b0;
        memIf.mem_rdata = '0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        tick();

        $display("[TB] reset state");
        checkOutput("rst_rd_req", memIf.mem_rd_req, 1'b0);
        checkOutput("rst_wr_req", memIf.mem_wr_req, 1'b0);
        checkOutput("rst_addr", memIf.mem_addr, '0);
        checkOutput("rst_wdata", memIf.mem_wdata, '0);
        checkOutput("rst_we", o_icache_block_we | o_dcache_block_we, 1'b0);
        checkOutput("rst_stall", o_stall, 1'b0);
        i_icache_miss = 1'b1;
        #1;
        checkOutput("rst_stall_miss", o_stall, 1'b1);
        tick();
        checkOutput("rst_hold_req", memIf.mem_rd_req, 1'b0);
        i_icache_miss = 1'b0;
        i_arst = 1'b1;
        tick();

        $display("[TB] clean icache miss");
        applyStimulus(1'b1, 64'h1000_0008, 1'b0, 1'b0, '0, '0, '0);
        #1;
        checkOutput("ic_stall", o_stall, 1'b1);
        tick();
        runRead(1'b0, 64'h1000_0000, {16{32'h1234_5678}});
        checkOutput("ic_stall_done", o_stall, 1'b0);
        checkOutput("ic_idle_req", memIf.mem_rd_req, 1'b0);

        $display("[TB] dirty dcache miss");
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 64'h3000_0000, 64'h2000_0040, {64{8'hA5}});
        tick();
        runWriteBack(64'h2000_0040, {64{8'hA5}}, 0);
        i_dcache_dirty = 1'b0;
        runRead(1'b1, 64'h3000_0000, {16{32'hCAFE_F00D}});

        $display("[TB] simultaneous misses");
        applyStimulus(1'b1, 64'h5000_0010, 1'b1, 1'b0, 64'h4000_0080, '0, '0);
        tick();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        runRead(1'b0, 64'h5000_0000, {16{32'h0BAD_0001}});
        tick();
        runRead(1'b1, 64'h4000_0080, {16{32'h0BAD_0002}});
`else
        runRead(1'b1, 64'h4000_0080, {16{32'h0BAD_0002}});
        tick();
        runRead(1'b0, 64'h5000_0000, {16{32'h0BAD_0001}});
`endif

        $display("[TB] ready held low");
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 64'h7100_0020, 64'h7000_0000, {16{32'hDEAD_BEEF}});
        tick();
        runWriteBack(64'h7000_0000, {16{32'hDEAD_BEEF}}, 5);
        i_dcache_dirty = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold_rd_req", memIf.mem_rd_req, 1'b1);
            checkOutput("hold_rd_addr", memIf.mem_addr, 64'h7100_0000);
            tick();
        end
        runRead(1'b1, 64'h7100_0000, {16{32'h5555_AAAA}});

        $display("[TB] reset in RD_WAIT");
        applyStimulus(1'b1, 64'h8000_0000, 1'b0, 1'b0, '0, '0, '0);
        tick();
        checkOutput("arst_pre_req", memIf.mem_rd_req, 1'b1);
        memIf.mem_ready = 1'b1;
        tick();
        memIf.mem_ready = 1'b0;
        i_arst = 1'b0;
        #1;
        checkOutput("arst_rd_req", memIf.mem_rd_req, 1'b0);
        checkOutput("arst_addr", memIf.mem_addr, '0);
        checkOutput("arst_we", o_icache_block_we | o_dcache_block_we, 1'b0);
        checkOutput("arst_block", o_refill_block, '0);
        checkOutput("arst_stall", o_stall, 1'b1);
        tick();
        i_arst = 1'b1;
        tick();
        runRead(1'b0, 64'h8000_0000, {16{32'h1357_9BDF}});

        $display("[TB] spurious done");
        memIf.mem_done  = 1'b1;
        memIf.mem_rdata = {16{32'hFFFF_0000}};
        tick();
        checkOutput("sp_idle_we", o_icache_block_we | o_dcache_block_we, 1'b0);
        checkOutput("sp_idle_req", memIf.mem_rd_req, 1'b0);
        i_icache_miss = 1'b1;
        i_icache_addr = 64'h9000_0000;
        tick();
        tick();
        checkOutput("sp_rdreq_hold", memIf.mem_rd_req, 1'b1);
        checkOutput("sp_rdreq_we", o_icache_block_we | o_dcache_block_we, 1'b0);
        memIf.mem_done  = 1'b0;
        memIf.mem_rdata = '0;
        runRead(1'b0, 64'h9000_0000, {16{32'h2468_ACE0}});

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/mem_refill_arbiter.md
# mem_refill_arbiter

- Sequences all block-level memory traffic for the cache hierarchy.
- Shares one block-wide memory port between instruction-cache and data-cache misses.
- For dirty data-cache misses, performs the victim write-back before the refill read.
- Returns the refill block to the requesting cache with a one-cycle block write enable, and holds the pipeline stall while any miss is outstanding.

## Interface

Parameters:
- ADDR_WIDTH, 64, address width.
- BLOCK_WIDTH, 512, cache block width.

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_arst  in  1  reset; asynchronous, active-low.
- i_icache_miss  in  1  instruction-cache miss; level, held until the cache hits.
- i_icache_addr  in  ADDR_WIDTH  instruction miss address.
- i_dcache_miss  in  1  data-cache miss (memory access and no hit); level.
- i_dcache_dirty  in  1  data-cache victim block is dirty.
- i_dcache_addr  in  ADDR_WIDTH  data miss address.
- i_dcache_addr_wb  in  ADDR_WIDTH  victim write-back address.
- i_dcache_block  in  BLOCK_WIDTH  victim block data.
- o_mem_rd_req  out  1  block read request.
- o_mem_wr_req  out  1  block write request.
- o_mem_addr  out  ADDR_WIDTH  request address.
- o_mem_wdata  out  BLOCK_WIDTH  write-back data.
- i_mem_ready  in  1  request accepted this cycle.
- i_mem_done  in  1  transaction complete; read data valid on i_mem_rdata.
- i_mem_rdata  in  BLOCK_WIDTH  refill block.
- o_refill_block  out  BLOCK_WIDTH  block to write into the granted cache.
- o_icache_block_we  out  1  instruction-cache block write pulse.
- o_dcache_block_we  out  1  data-cache block write pulse.
- o_stall  out  1  pipeline stall.

## Operation

States are IDLE, WB_REQ, WB_WAIT, RD_REQ, RD_WAIT, FILL.

IDLE:
- Samples both miss inputs and picks a grant; the grant is registered until the FSM returns to IDLE.
- Granting dcache with i_dcache_dirty=1:
  - latches i_dcache_addr_wb and i_dcache_block into the write-back registers;
  - latches i_dcache_addr into the miss-address register;
  - goes to WB_REQ.
- Granting dcache clean, or granting icache: latches the miss address and goes to RD_REQ.
- No miss: stays in IDLE.

Write-back:
- WB_REQ drives o_mem_wr_req=1, o_mem_addr = latched victim address, o_mem_wdata = latched victim block.
- WB_REQ goes to WB_WAIT on i_mem_ready.
- WB_WAIT goes to RD_REQ on i_mem_done.

Refill:
- RD_REQ drives o_mem_rd_req=1 with o_mem_addr = latched miss address, with the low log2(BLOCK_WIDTH/8) bits forced to 0.
- RD_REQ goes to RD_WAIT on i_mem_ready.
- RD_WAIT latches i_mem_rdata into the refill register on i_mem_done, then goes to FILL.
- FILL drives o_refill_block from the refill register, pulses the granted cache's block_we for one cycle, then returns to IDLE.

Output rules:
- o_stall = i_icache_miss | i_dcache_miss | (state != IDLE); combinational.
- Request, address and write-data outputs are decoded from the registered state and latched registers only. Memory inputs never reach them combinationally.
- Request, address and write-data outputs are 0 in any state that does not drive them.

## Timing

Reset (i_arst=0, at any time, including mid-transaction):
- FSM goes to IDLE; grant and round-robin pointer are cleared.
- Latched address, victim and refill registers are zeroed.
- All outputs are 0 except o_stall, which follows the miss inputs combinationally.
- An in-flight memory transaction is abandoned; the memory side is reset by the same signal.

Latency:
- Request: a miss sampled in IDLE at cycle t gives o_mem_*_req=1 at t+1.
- Fill: i_mem_done at cycle t gives block_we=1 at t+1 and IDLE at t+2.
- Clean miss with 1-cycle ready and N-cycle done: 1 (grant) + 1 (ready) + N + 1 (FILL) cycles.

Handshake rules:
- A request stays asserted, with address and data stable, until the cycle i_mem_ready=1.
- i_mem_done is used only in the WAIT states. Memory guarantees done arrives at least one cycle after ready; done outside the WAIT states is ignored.

Completion:
- The cache writes its block at the end of the FILL cycle, so its miss is low in the following IDLE cycle and no regrant occurs.
- A miss input dropping after grant does not abort the sequence.

Simultaneous misses in IDLE: arbitrated per Configuration. The loser stays pending because its miss is level-held.

## Configuration

MEM_ARB_ROUND_ROBIN_EN:
- Defined: round-robin arbitration. A 1-bit last-granted register, updated at each grant, gives priority on simultaneous misses to the requester not granted last.
- Undefined: fixed priority, dcache over icache. No pointer register is built.

## Test plan

- Clean icache miss, addr 0x1000_0008, ready at +1, done at +3:
  - o_mem_rd_req=1 with addr 0x1000_0000;
  - then o_icache_block_we one-cycle pulse with o_refill_block = the returned pattern;
  - o_stall low once the miss drops.
- Dirty dcache miss, victim 0x2000_0040 / 0xA5.., miss 0x3000_0000:
  - o_mem_wr_req=1 with 0x2000_0040 and the victim data first;
  - after done, o_mem_rd_req=1 with 0x3000_0000;
  - then o_dcache_block_we pulse.
- Both misses asserted in the same cycle:
  - without the macro, dcache is served first, then icache;
  - with the macro, after a prior dcache grant, icache is served first.
- Ready held low for 5 cycles: request, address and data stay stable; no state advance.
- i_arst=0 in RD_WAIT:
  - all outputs 0, FSM in IDLE;
  - after release with the miss still high, a fresh o_mem_rd_req=1 one cycle later.
- Spurious i_mem_done in IDLE and in RD_REQ: ignored; no block_we.
